// File: rtl/buffer_stream_reader.sv
// buffer_stream_reader
// Drains a linear byte range from one read port of the staging buffer into a
// valid/ready byte stream. Each address is held for two cycles because the
// buffer registers the row read but muxes the byte lane from the live address.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no transfer; start sampled here, done pulses here
// S_FETCH | buf_addr = ptr, row read launched inside the buffer
// S_CAPT  | buf_rdata valid for ptr; load into stream slot when it is free
// S_DRAIN | last byte loaded, waiting for its handshake before done
module buffer_stream_reader #(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] buf_addr,
    output logic              buf_we,
    output logic [7:0]        buf_wdata,
    input  logic [7:0]        buf_rdata,
    output logic              m_valid,
    output logic [7:0]        m_data,
    input  logic              m_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_CAPT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [LEN_W-1:0]  rem_q;
    logic              m_valid_q;
    logic [7:0]        m_data_q;
    logic              done_q;

    logic handshake;
    logic slot_free;
    logic load;
    logic cmd_go;
    logic cmd_zero;
    logic last_byte;

    // Stream slot bookkeeping: a byte may be loaded in the same cycle the
    // previous one is accepted, so the slot counts as free on a handshake.
    assign handshake = m_valid_q && m_ready;
    assign slot_free = !m_valid_q || handshake;
    assign load      = (state_q == S_CAPT) && slot_free;
    assign last_byte = (rem_q <= LEN_W'(1));

    // A zero-length command completes without touching the buffer.
    assign cmd_go   = (state_q == S_IDLE) && start && (length != '0);
    assign cmd_zero = (state_q == S_IDLE) && start && (length == '0);

    // Next-state selection for the fetch/capture walk.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_go) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                if (slot_free) begin
                    state_d = last_byte ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (handshake) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register, address/length counters, stream slot and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (cmd_go) begin
                ptr_q <= base_addr;
                rem_q <= length;
            end else if (load) begin
                ptr_q <= ptr_q + ADDR_W'(1);
                rem_q <= rem_q - LEN_W'(1);
            end

            if (load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= buf_rdata;
            end else if (handshake) begin
                m_valid_q <= 1'b0;
            end

            done_q <= cmd_zero || ((state_q == S_DRAIN) && handshake);
        end
    end

    // The buffer address follows the pointer directly; it already holds
    // across FETCH and CAPT and wraps naturally at the top of the port.
    assign buf_addr  = ptr_q;
    assign buf_we    = 1'b0;
    assign buf_wdata = 8'h00;

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_buffer_stream_reader.sv
// Bench for buffer_stream_reader: a byte-port model of the staging buffer
// (registered row, live lane mux), directed command sequences, and a
// scoreboard that pops expected bytes on each stream handshake.
module tb_buffer_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] base_addr;
    logic [14:0] length;
    logic        busy;
    logic        done;
    logic [13:0] buf_addr;
    logic        buf_we;
    logic [7:0]  buf_wdata;
    logic [7:0]  buf_rdata;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mem [0:16383];
    logic [63:0] row_q;
    logic [7:0]  exp_q [$];

    buffer_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .buf_addr  (buf_addr),
        .buf_we    (buf_we),
        .buf_wdata (buf_wdata),
        .buf_rdata (buf_rdata),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    // Buffer model: whole 8-byte row registered, lane picked from live address.
    always @(posedge clk) begin
        for (int l = 0; l < 8; l++) begin
            row_q[8*l +: 8] <= mem[{buf_addr[13:3], 3'(l)}];
        end
    end
    assign buf_rdata = row_q[{buf_addr[2:0], 3'b000} +: 8];

    // Scoreboard monitor: every accepted byte must match the queue head.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL stream_byte: unexpected byte %h, none expected", m_data);
            end else begin
                logic [7:0] want;
                want = exp_q.pop_front();
                if (m_data !== want) begin
                    fails++;
                    $display("FAIL stream_byte: got %h want %h", m_data, want);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 0; returns in cycle 1 with start dropped.
    task automatic start_cmd(input logic [13:0] b, input logic [14:0] n);
        start     = 1'b1;
        base_addr = b;
        length    = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk(name, 32'(seen), 32'd1);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i ^ 8'h5A);
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
        tick(); tick();

        chk("rst_busy",    32'(busy),      32'd0);
        chk("rst_done",    32'(done),      32'd0);
        chk("rst_m_valid", 32'(m_valid),   32'd0);
        chk("rst_m_data",  32'(m_data),    32'd0);
        chk("rst_buf_addr",32'(buf_addr),  32'd0);
        chk("buf_we",      32'(buf_we),    32'd0);
        chk("buf_wdata",   32'(buf_wdata), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic read with exact cycle timing.
        mem[5] = 8'hA0; mem[6] = 8'hA1; mem[7] = 8'hA2; mem[8] = 8'hA3;
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        start_cmd(14'h0005, 15'd4);
        for (int c = 1; c <= 11; c++) begin
            logic vexp;
            vexp = (c == 3) || (c == 5) || (c == 7) || (c == 9);
            chk($sformatf("basic_valid_c%0d", c), 32'(m_valid), 32'(vexp));
            chk($sformatf("basic_done_c%0d", c),  32'(done),    32'(c == 10));
            chk($sformatf("basic_busy_c%0d", c),  32'(busy),    32'(c <= 9));
            if (vexp) chk($sformatf("basic_data_c%0d", c), 32'(m_data), 32'(8'hA0 + 8'((c - 3) / 2)));
            tick();
        end

        // Lane/row crossing: address held two cycles each.
        mem[6] = 8'h10; mem[7] = 8'h11; mem[8] = 8'h12; mem[9] = 8'h13;
        exp_q.push_back(8'h10); exp_q.push_back(8'h11);
        exp_q.push_back(8'h12); exp_q.push_back(8'h13);
        start_cmd(14'h0006, 15'd4);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("cross_addr_c%0d", c), 32'(buf_addr), 32'(6 + (c - 1) / 2));
            tick();
        end
        wait_done("cross_done", 20);

        // Address wrap at the top of the port.
        mem[16382] = 8'hC0; mem[16383] = 8'hC1; mem[0] = 8'hC2;
        exp_q.push_back(8'hC0); exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
        start_cmd(14'h3FFE, 15'd3);
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) chk("wrap_addr_c1", 32'(buf_addr), 32'h3FFE);
            if (c == 3) chk("wrap_addr_c3", 32'(buf_addr), 32'h3FFF);
            if (c == 5) chk("wrap_addr_c5", 32'(buf_addr), 32'h0000);
            tick();
        end
        wait_done("wrap_done", 20);

        // Backpressure: m_ready low in cycles 3..8.
        mem[14'h100] = 8'h31; mem[14'h101] = 8'h32; mem[14'h102] = 8'h33;
        exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h33);
        start_cmd(14'h0100, 15'd3);
        tick();
        tick();
        m_ready = 1'b0;
        for (int c = 3; c <= 8; c++) begin
            chk($sformatf("bp_valid_c%0d", c), 32'(m_valid),  32'd1);
            chk($sformatf("bp_data_c%0d", c),  32'(m_data),   32'h31);
            chk($sformatf("bp_addr_c%0d", c),  32'(buf_addr), 32'h101);
            tick();
        end
        m_ready = 1'b1;
        for (int c = 9; c <= 13; c++) begin
            chk($sformatf("bp_done_c%0d", c), 32'(done), 32'(c == 13));
            if (c == 10) chk("bp_data_c10", 32'(m_data), 32'h32);
            if (c == 12) chk("bp_data_c12", 32'(m_data), 32'h33);
            tick();
        end

        // Zero length: done next cycle, no stream activity, not busy.
        start_cmd(14'h0200, 15'd0);
        chk("zero_done_c1",  32'(done),    32'd1);
        chk("zero_busy_c1",  32'(busy),    32'd0);
        chk("zero_valid_c1", 32'(m_valid), 32'd0);
        tick();
        chk("zero_done_c2",  32'(done),    32'd0);
        chk("zero_valid_c2", 32'(m_valid), 32'd0);
        tick();

        // Start while busy is ignored.
        mem[14'h10] = 8'hD0; mem[14'h11] = 8'hD1;
        exp_q.push_back(8'hD0); exp_q.push_back(8'hD1);
        start_cmd(14'h0010, 15'd2);
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) begin
                start = 1'b1; base_addr = 14'h0300; length = 15'd5;
            end else begin
                start = 1'b0;
            end
            if (c == 3) chk("ign_addr_c3", 32'(buf_addr), 32'h11);
            chk($sformatf("ign_done_c%0d", c), 32'(done), 32'(c == 6));
            chk($sformatf("ign_busy_c%0d", c), 32'(busy), 32'(c <= 5));
            tick();
        end
        start = 1'b0;

        // Reset in cycle 6 of a len=8 transfer: only bytes 0 and 1 escape.
        for (int i = 0; i < 8; i++) mem[14'h40 + 14'(i)] = 8'h50 + 8'(i);
        exp_q.push_back(8'h50); exp_q.push_back(8'h51);
        start_cmd(14'h0040, 15'd8);
        for (int c = 1; c < 6; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_valid", 32'(m_valid),  32'd0);
        chk("rst_mid_busy",  32'(busy),     32'd0);
        chk("rst_mid_addr",  32'(buf_addr), 32'd0);
        for (int c = 7; c <= 12; c++) begin
            chk($sformatf("rst_mid_nodone_c%0d", c), 32'(done), 32'd0);
            tick();
        end
        chk("rst_mid_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(8'h50); exp_q.push_back(8'h51);
        start_cmd(14'h0040, 15'd2);
        wait_done("fresh_done", 20);

        tick(); tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
